// File: rtl/ksk_pkg.sv
// Shared KSK address-space constants and FSM state type, used by both the
// issuing side and the receive-side address tracker.
package ksk_pkg;
  localparam int KSK_ADDR_MAX     = 511;
  localparam int KSK_INDEX_MAX    = 11;
  localparam int KSK_ROW_LEN      = KSK_ADDR_MAX + 1;
  localparam int KSK_STAGE_STRIDE = KSK_ROW_LEN * (KSK_INDEX_MAX + 1);

  localparam int KSK_ADDR_W  = 9;
  localparam int KSK_INDEX_W = 4;
  localparam int KSK_STAGE_W = 4;
  localparam int KSK_WORD_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ksk_state_e;
endpackage

// File: rtl/ksk_addr_cnt.sv
// Nested addr/index/stage counter with a parallel linear word counter; the word
// is incremented alongside the nested counters so it never needs a multiplier.
module ksk_addr_cnt
  import ksk_pkg::*;
#(
  parameter int ADDR_MAX  = KSK_ADDR_MAX,
  parameter int INDEX_MAX = KSK_INDEX_MAX,
  parameter int STAGE_W   = KSK_STAGE_W,
  parameter int WORD_W    = KSK_WORD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   adv_i,
  input  logic [STAGE_W-1:0]     num_stage_i,
  output logic [KSK_ADDR_W-1:0]  addr_o,
  output logic [KSK_INDEX_W-1:0] index_o,
  output logic [STAGE_W-1:0]     stage_o,
  output logic [WORD_W-1:0]      word_o,
  output logic                   last_o
);
  localparam logic [KSK_ADDR_W-1:0]  ADDR_LAST  = KSK_ADDR_W'(ADDR_MAX);
  localparam logic [KSK_INDEX_W-1:0] INDEX_LAST = KSK_INDEX_W'(INDEX_MAX);

  logic [KSK_ADDR_W-1:0]  addr_q,  addr_d;
  logic [KSK_INDEX_W-1:0] index_q, index_d;
  logic [STAGE_W-1:0]     stage_q, stage_d;
  logic [WORD_W-1:0]      word_q,  word_d;

  always_comb begin
    addr_d  = addr_q;
    index_d = index_q;
    stage_d = stage_q;
    word_d  = word_q;
    if (clr_i) begin
      addr_d  = '0;
      index_d = '0;
      stage_d = '0;
      word_d  = '0;
    end else if (adv_i) begin
      word_d = word_q + WORD_W'(1);
      if (addr_q == ADDR_LAST) begin
        addr_d = '0;
        if (index_q == INDEX_LAST) begin
          index_d = '0;
          stage_d = stage_q + STAGE_W'(1);
        end else begin
          index_d = index_q + KSK_INDEX_W'(1);
        end
      end else begin
        addr_d = addr_q + KSK_ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      index_q <= '0;
      stage_q <= '0;
      word_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      index_q <= index_d;
      stage_q <= stage_d;
      word_q  <= word_d;
    end
  end

  assign addr_o  = addr_q;
  assign index_o = index_q;
  assign stage_o = stage_q;
  assign word_o  = word_q;
  assign last_o  = (stage_q == num_stage_i - STAGE_W'(1)) &&
                   (index_q == INDEX_LAST) && (addr_q == ADDR_LAST);
endmodule

// File: rtl/ksk_addr_issue.sv
// Issues the linear KSK address word stream (stage/index/addr) over a
// valid/ready interface, one word per handshake, for a commanded stage count.
module ksk_addr_issue
  import ksk_pkg::*;
#(
  parameter int ADDR_MAX  = KSK_ADDR_MAX,
  parameter int INDEX_MAX = KSK_INDEX_MAX,
  parameter int STAGE_W   = KSK_STAGE_W,
  parameter int WORD_W    = KSK_WORD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [STAGE_W-1:0]     i_num_stage,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WORD_W-1:0]      o_ksk_addr_word,
  output logic [STAGE_W-1:0]     o_ksk_stage,
  output logic [KSK_INDEX_W-1:0] o_ksk_index,
  output logic [KSK_ADDR_W-1:0]  o_ksk_addr,
  output logic                   o_last
);
  ksk_state_e         state_q;
  logic [STAGE_W-1:0] num_stage_q;
  logic               valid_q, busy_q, done_q;
  logic               hs, cnt_last, cnt_clr, cnt_adv;

  assign hs      = valid_q & i_ready;
  assign cnt_clr = (state_q == ST_IDLE) && i_start && (i_num_stage != '0);
  // The final beat does not advance, so the outputs keep the last word after DONE.
  assign cnt_adv = hs & ~cnt_last;

  ksk_addr_cnt #(
    .ADDR_MAX (ADDR_MAX),
    .INDEX_MAX(INDEX_MAX),
    .STAGE_W  (STAGE_W),
    .WORD_W   (WORD_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .adv_i      (cnt_adv),
    .num_stage_i(num_stage_q),
    .addr_o     (o_ksk_addr),
    .index_o    (o_ksk_index),
    .stage_o    (o_ksk_stage),
    .word_o     (o_ksk_addr_word),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_stage_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            if (i_num_stage != '0) begin
              state_q     <= ST_RUN;
              num_stage_q <= i_num_stage;
              valid_q     <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hs && cnt_last) begin
            state_q <= ST_DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_last  = cnt_last & valid_q;
endmodule

// File: tb/tb_ksk_addr_issue.sv
// Directed bench for ksk_addr_issue: full sequences, stage wrap, backpressure,
// zero-stage command, ignored restart and asynchronous reset mid-run.
module tb_ksk_addr_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [3:0]  i_num_stage;
  logic        o_busy, o_done, o_valid, i_ready, o_last;
  logic [31:0] o_ksk_addr_word;
  logic [3:0]  o_ksk_stage, o_ksk_index;
  logic [8:0]  o_ksk_addr;

  int n_total = 0;
  int n_pass  = 0;

  ksk_addr_issue dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_num_stage    (i_num_stage),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_ksk_addr_word(o_ksk_addr_word),
    .o_ksk_stage    (o_ksk_stage),
    .o_ksk_index    (o_ksk_index),
    .o_ksk_addr     (o_ksk_addr),
    .o_last         (o_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a sequence of ns stages and follows it beat by beat against a
  // word counter kept in the bench; the expected stage/index/addr come from
  // dividing that word, mirroring what the receiving tracker reconstructs.
  task automatic run_seq(input string tag, input int ns, input bit rnd, input int mid_start_at);
    int  exp_word, total, cycles, limit, fails0;
    bit  hs, lst, finished;
    logic [63:0] exp_pk;
    if (n_total != n_pass) do_reset();
    total = ns * 6144;
    limit = total * 4 + 64;
    @(negedge clk);
    i_start = 1'b1;
    i_num_stage = 4'(ns);
    i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_start"}, 64'({o_valid, o_busy, o_done}), 64'(3'b110));
    exp_word = 0;
    cycles = 0;
    finished = 1'b0;
    fails0 = n_total - n_pass;
    while (!finished && cycles <= limit) begin
      lst = (exp_word == total - 1);
      exp_pk = 64'({1'b1, 32'(exp_word), 4'(exp_word / 6144), 4'((exp_word % 6144) / 512),
                    9'(exp_word % 512), lst});
      check({tag, "_beat"},
            64'({o_valid, o_ksk_addr_word, o_ksk_stage, o_ksk_index, o_ksk_addr, o_last}), exp_pk);
      if ((n_total - n_pass) != fails0) break;
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (exp_word == mid_start_at) begin
        i_start = 1'b1;
        i_num_stage = 4'd5;
      end else begin
        i_start = 1'b0;
      end
      hs = i_ready;
      @(negedge clk);
      cycles++;
      if (hs) begin
        if (lst) finished = 1'b1;
        else exp_word++;
      end
    end
    i_start = 1'b0;
    check({tag, "_complete"}, 64'(finished), 64'(1));
    if (finished) begin
      check({tag, "_done"}, 64'({o_valid, o_busy, o_done, o_last, o_ksk_addr_word}),
            64'({4'b0010, 32'(total - 1)}));
      @(negedge clk);
      check({tag, "_idle"}, 64'({o_valid, o_busy, o_done, o_ksk_addr_word}),
            64'({3'b000, 32'(total - 1)}));
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    i_start = 1'b0;
    i_ready = 1'b0;
    i_num_stage = 4'd0;
    #1;
    check("reset_state", 64'({o_valid, o_busy, o_done, o_last, o_ksk_addr_word, o_ksk_stage,
                              o_ksk_index, o_ksk_addr}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'({o_valid, o_busy, o_done}), 64'(0));

    // One stage at full rate, with a stray start pulse at word 100.
    run_seq("basic", 1, 1'b0, 100);
    // Two stages: crosses the stage boundary at word 6144.
    run_seq("wrap", 2, 1'b0, -1);
    // Random backpressure: stalls must hold the word, nothing skipped.
    run_seq("bp", 1, 1'b1, -1);

    // Zero stages: straight to DONE, no words.
    @(negedge clk);
    i_start = 1'b1;
    i_num_stage = 4'd0;
    i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("zero_done", 64'({o_valid, o_busy, o_done}), 64'(3'b001));
    @(negedge clk);
    check("zero_idle", 64'({o_valid, o_busy, o_done}), 64'(3'b000));

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    i_start = 1'b1;
    i_num_stage = 4'd1;
    i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while (o_ksk_addr_word != 32'd3000 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reached", 64'(o_ksk_addr_word), 64'(3000));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 64'({o_valid, o_busy, o_done, o_last, o_ksk_addr_word, o_ksk_stage,
                              o_ksk_index, o_ksk_addr}), 64'(0));
    @(negedge clk);
    check("reset_no_done", 64'({o_valid, o_busy, o_done}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 64'({o_valid, o_busy, o_done}), 64'(0));

    // Restart from word 0 with three stages.
    run_seq("restart3", 3, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
